// File: rtl/rotate_seq_ctrl_pkg.sv
// Shared types and step constants for the iterative rotate controller.
// The optional right-rotate direction is enabled by defining ROTATE_RIGHT_EN.
package rotate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_STEP_BITS = 2;
  localparam int STEP_MAX      = (1 << DEF_STEP_BITS) - 1;

endpackage

// File: rtl/rotate_seq_ctrl_if.sv
// Requester-side bus of the rotate controller, plus a debug view of the FSM state.
// ROTATE_RIGHT_EN adds the dir signal (1 = rotate right).
interface rotate_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  import rotate_seq_pkg::*;

  // Handshake: start is only honoured while busy=0; X, amount (and dir) are
  // captured on that edge. done pulses for one cycle and Y is final from then on.
  logic                     start;
  logic [WIDTH-1:0]         X;
  logic [$clog2(WIDTH)-1:0] amount;
`ifdef ROTATE_RIGHT_EN
  logic                     dir;
`endif
  logic                     busy;
  logic                     done;
  logic [WIDTH-1:0]         Y;
  state_t                   dbg_state;

`ifdef ROTATE_RIGHT_EN
  modport master (output start, X, amount, dir, input busy, done, Y, dbg_state);
  modport slave  (input start, X, amount, dir, output busy, done, Y, dbg_state);
`else
  modport master (output start, X, amount, input busy, done, Y, dbg_state);
  modport slave  (input start, X, amount, output busy, done, Y, dbg_state);
`endif

endinterface

// File: rtl/rotate_seq_ctrl_step.sv
// Combinational step rotator: rotates A by 0..2**STEP_BITS-1 positions.
// With ROTATE_RIGHT_EN defined, dir=1 selects a right rotate.
module rotate_step #(
  parameter int WIDTH     = 16,
  parameter int STEP_BITS = 2
) (
  input  logic [WIDTH-1:0]     A,
`ifdef ROTATE_RIGHT_EN
  input  logic                 dir,
`endif
  input  logic [STEP_BITS-1:0] s,
  output logic [WIDTH-1:0]     Y
);

  logic [WIDTH-1:0] w_rotl;

  // A shift by WIDTH yields zero, so s=0 passes A through unchanged.
  assign w_rotl = (A << s) | (A >> (WIDTH - int'(s)));

`ifdef ROTATE_RIGHT_EN
  logic [WIDTH-1:0] w_rotr;
  assign w_rotr = (A >> s) | (A << (WIDTH - int'(s)));
  assign Y      = dir ? w_rotr : w_rotl;
`else
  assign Y      = w_rotl;
`endif

endmodule

// File: rtl/rotate_seq_ctrl.sv
// Iterative rotate controller: walks one rotate_step over several cycles to
// build a full WIDTH-bit rotate. ROTATE_RIGHT_EN adds a captured direction.
module rotate_seq_ctrl
  import rotate_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int STEP_BITS = DEF_STEP_BITS
) (
  input  logic             clk,
  input  logic             reset_n,
  rotate_seq_ctrl_if.slave bus
);

  localparam int AW = $clog2(WIDTH);
  localparam logic [AW-1:0] STEP_MAX_AW = AW'((1 << STEP_BITS) - 1);

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_y, w_y_next, w_step_y;
  logic [AW-1:0]    r_rem, w_rem_next, w_step_aw;
  logic [STEP_BITS-1:0] w_step;
`ifdef ROTATE_RIGHT_EN
  logic             r_dir, w_dir_next;
`endif

  // Largest step the rotator can do without overshooting the remaining distance.
  assign w_step_aw = (r_rem > STEP_MAX_AW) ? STEP_MAX_AW : r_rem;
  assign w_step    = w_step_aw[STEP_BITS-1:0];

  rotate_step #(
    .WIDTH     (WIDTH),
    .STEP_BITS (STEP_BITS)
  ) u_step (
    .A   (r_y),
`ifdef ROTATE_RIGHT_EN
    .dir (r_dir),
`endif
    .s   (w_step),
    .Y   (w_step_y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_y     <= '0;
      r_rem   <= '0;
`ifdef ROTATE_RIGHT_EN
      r_dir   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_y     <= w_y_next;
      r_rem   <= w_rem_next;
`ifdef ROTATE_RIGHT_EN
      r_dir   <= w_dir_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_y_next     = r_y;
    w_rem_next   = r_rem;
`ifdef ROTATE_RIGHT_EN
    w_dir_next   = r_dir;
`endif
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_y_next     = bus.X;
          w_rem_next   = bus.amount;
`ifdef ROTATE_RIGHT_EN
          w_dir_next   = bus.dir;
`endif
          w_state_next = (bus.amount == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        w_y_next   = w_step_y;
        w_rem_next = r_rem - w_step_aw;
        if (w_rem_next == '0) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.Y         = r_y;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Directed bench for rotate_seq_ctrl: expected results go into a queue when an
// operation is issued; a monitor pops and checks them on every done pulse.
module tb_rotate_seq_ctrl;
  import rotate_seq_pkg::*;

  localparam int W = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [W-1:0] exp_q[$];
  int           exp_edge_q[$];

  rotate_seq_ctrl_if #(.WIDTH(W)) bus ();

  rotate_seq_ctrl #(
    .WIDTH     (W),
    .STEP_BITS (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 at edge %0d, expected no pending result", cyc);
      end else begin
        logic [W-1:0] y_exp;
        int           e_exp;
        y_exp = exp_q.pop_front();
        e_exp = exp_edge_q.pop_front();
        check("result_y", bus.Y, y_exp);
        check("done_edge", cyc, e_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] x, input logic [3:0] amt, input logic d,
                       input int lat, input logic [W-1:0] y_exp);
    @(negedge clk);
    exp_q.push_back(y_exp);
    exp_edge_q.push_back(cyc + 1 + lat);
    bus.start  = 1'b1;
    bus.X      = x;
    bus.amount = amt;
`ifdef ROTATE_RIGHT_EN
    bus.dir    = d;
`else
    if (d) $display("note: dir ignored in left-only build");
`endif
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_accept", bus.busy, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (!bus.busy) seen = 1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle_timeout: busy still 1 after %0d cycles, expected 0", budget);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0;
    bus.start  = 1'b0;
    bus.X      = '0;
    bus.amount = '0;
`ifdef ROTATE_RIGHT_EN
    bus.dir    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_y", bus.Y, 0);
    check("reset_state", bus.dbg_state, IDLE);
    reset_n = 1'b1;

    // 1: amount 5 -> two shift steps
    issue(16'h0001, 4'd5, 1'b0, 2, 16'h0020);
    wait_idle(20);

    // 2: amount 0 -> done on the sampling edge, busy for one cycle only
    issue(16'hA5C3, 4'd0, 1'b0, 0, 16'hA5C3);
    @(posedge clk);
    #1;
    check("busy_one_cycle", bus.busy, 0);
    wait_idle(20);

    // 3: maximum amount
    issue(16'h8001, 4'd15, 1'b0, 5, 16'hC000);
    wait_idle(20);

    // Further boundaries: exactly one full step, partial last step
    issue(16'h1001, 4'd3, 1'b0, 1, 16'h8008);
    wait_idle(20);
    issue(16'hF00F, 4'd7, 1'b0, 3, 16'h07F8);
    wait_idle(20);
    issue(16'h0F00, 4'd6, 1'b0, 2, 16'hC003);
    wait_idle(20);

    // 4: start during SHIFT must be ignored
    issue(16'h0001, 4'd4, 1'b0, 2, 16'h0010);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.X      = 16'hFFFF;
    bus.amount = 4'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle(20);

    // Back-to-back: start held high is accepted again in the IDLE after DONE
    @(negedge clk);
    e0 = cyc + 1;
    exp_q.push_back(16'h91A0);
    exp_edge_q.push_back(e0 + 1);
    exp_q.push_back(16'h91A0);
    exp_edge_q.push_back(e0 + 4);
    bus.start  = 1'b1;
    bus.X      = 16'h1234;
    bus.amount = 4'd3;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_rearmed", bus.busy, 1);
    wait_idle(20);

    // 5: asynchronous reset mid-SHIFT discards the operation
    @(negedge clk);
    bus.start  = 1'b1;
    bus.X      = 16'h0001;
    bus.amount = 4'd15;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    check("busy_before_abort", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_y", bus.Y, 0);
    check("abort_state", bus.dbg_state, IDLE);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    issue(16'h0003, 4'd1, 1'b0, 1, 16'h0006);
    wait_idle(20);

`ifdef ROTATE_RIGHT_EN
    // 6: right rotate
    issue(16'h0001, 4'd4, 1'b1, 2, 16'h1000);
    wait_idle(20);
    issue(16'h8001, 4'd15, 1'b1, 5, 16'h0003);
    wait_idle(20);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
